// File: rtl/insn_fetch_buffer_if.sv
// Instruction-memory req/ack bus between the fetch buffer and memory.
// The master holds m_req and m_addr until m_ack completes the request.
interface insn_fetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_ack;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_req,
    output m_addr,
    input  m_ack,
    input  m_data
  );

  modport slave (
    input  m_req,
    input  m_addr,
    output m_ack,
    output m_data
  );
endinterface

// File: rtl/insn_fetch_buffer.sv
// Two-entry instruction fetch buffer (current + sequential prefetch).
// The buffer refills from a req/ack memory and stalls the core on a miss.
module insn_fetch_buffer #(
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h00001000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [DATA_W-1:0]    i_data,
  output logic                 stall,
  input  logic                 flush,
  insn_fetch_buffer_if.master  mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEMAND,
    S_PREFETCH
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic              r_m_req, w_m_req_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic              r_discard;

  logic              r_cur_v, r_pf_v;
  logic [ADDR_W-1:0] r_cur_tag, r_pf_tag;
  logic [DATA_W-1:0] r_cur_data, r_pf_data;

  logic              w_hit_c, w_hit_p, w_promote;
  logic              w_nc_v, w_pf_ok, w_ack, w_fill;
  logic [ADDR_W-1:0] w_nc_tag, w_nxt_tag;

  assign mem.m_req  = r_m_req;
  assign mem.m_addr = r_m_addr;

  always_comb begin
    w_hit_c   = r_cur_v && (i_addr == r_cur_tag);
    w_hit_p   = r_pf_v && (i_addr == r_pf_tag);
    w_promote = w_hit_p && !w_hit_c;
    stall     = !(w_hit_c || w_hit_p);
    i_data    = w_hit_c ? r_cur_data :
                w_hit_p ? r_pf_data  : '0;
    // cur/pf as they will look after this edge's promotion
    w_nc_v    = w_promote || r_cur_v;
    w_nc_tag  = w_promote ? r_pf_tag : r_cur_tag;
    w_nxt_tag = w_nc_tag + ONE;
    w_pf_ok   = !w_promote && r_pf_v &&
                (r_pf_tag == w_nxt_tag);
    w_ack     = r_m_req && mem.m_ack;
    w_fill    = w_ack && !r_discard && !flush;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_m_req_nxt  = r_m_req;
    w_m_addr_nxt = r_m_addr;
    unique case (r_state)
      S_IDLE: begin
        if (stall) begin
          w_state_nxt  = S_DEMAND;
          w_m_req_nxt  = 1'b1;
          w_m_addr_nxt = i_addr;
        end else if (!flush && w_nc_v && !w_pf_ok) begin
          w_state_nxt  = S_PREFETCH;
          w_m_req_nxt  = 1'b1;
          w_m_addr_nxt = w_nxt_tag;
        end
      end
      S_DEMAND, S_PREFETCH: begin
        if (w_ack) begin
          w_state_nxt = S_IDLE;
          w_m_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_m_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m_req   <= 1'b0;
      r_m_addr  <= RESET_VECTOR;
      r_discard <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_m_req  <= w_m_req_nxt;
      r_m_addr <= w_m_addr_nxt;
      if (w_ack)
        r_discard <= 1'b0;
      else if (flush && r_m_req)
        r_discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_v    <= 1'b0;
      r_cur_tag  <= RESET_VECTOR;
      r_cur_data <= '0;
      r_pf_v     <= 1'b0;
      r_pf_tag   <= RESET_VECTOR;
      r_pf_data  <= '0;
    end else if (flush) begin
      r_cur_v <= 1'b0;
      r_pf_v  <= 1'b0;
    end else begin
      if (w_promote) begin
        r_cur_v    <= 1'b1;
        r_cur_tag  <= r_pf_tag;
        r_cur_data <= r_pf_data;
        r_pf_v     <= 1'b0;
      end
      // a fill lands after promotion so it wins the same edge
      if (w_fill && r_state == S_DEMAND) begin
        r_cur_v    <= 1'b1;
        r_cur_tag  <= r_m_addr;
        r_cur_data <= mem.m_data;
      end
      if (w_fill && r_state == S_PREFETCH) begin
        r_pf_v    <= 1'b1;
        r_pf_tag  <= r_m_addr;
        r_pf_data <= mem.m_data;
      end
    end
  end

endmodule

// File: tb/tb_insn_fetch_buffer.sv
// Directed bench for insn_fetch_buffer with a latency-programmable memory.
// Memory word for address a is 32'hDEAD0000 + a - 32'hFFF.
module tb_insn_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        stall;
  logic        flush;

  insn_fetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  insn_fetch_buffer #(
    .ADDR_W(32),
    .DATA_W(32),
    .RESET_VECTOR(32'h00001000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_addr(i_addr),
    .i_data(i_data),
    .stall(stall),
    .flush(flush),
    .mem(bus.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          lat = 0;
  int          cnt = 0;
  logic        ack_auto = 1'b0;
  logic [31:0] dat_auto = '0;
  logic        ack_frc = 1'b0;
  logic [31:0] dat_frc = '0;

  assign bus.m_ack  = ack_auto | ack_frc;
  assign bus.m_data = ack_frc ? dat_frc : dat_auto;

  // Responder: acks after lat idle cycles of a held request
  always @(negedge clk) begin
    if (!bus.m_req) begin
      ack_auto = 1'b0;
      cnt      = 0;
    end else if (cnt == lat) begin
      ack_auto = 1'b1;
      dat_auto = 32'hDEAD0000 + bus.m_addr - 32'h00000FFF;
      cnt      = 0;
    end else begin
      ack_auto = 1'b0;
      cnt      = cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    i_addr = 32'h00001000;
    flush  = 1'b0;

    // reset state
    nxt();
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_data", i_data, 32'd0);
    chk("rst_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_addr", bus.m_addr, 32'h00001000);
    reset = 1'b0;
    #1;
    chk("t1_stall0", {31'd0, stall}, 32'd1);

    // 1: demand miss with one-cycle ack
    nxt();
    chk("t1_req", {31'd0, bus.m_req}, 32'd1);
    chk("t1_addr", bus.m_addr, 32'h00001000);
    chk("t1_stall1", {31'd0, stall}, 32'd1);
    nxt();
    chk("t1_hit", {31'd0, stall}, 32'd0);
    chk("t1_data", i_data, 32'hDEAD0001);
    chk("t1_req_dn", {31'd0, bus.m_req}, 32'd0);
    nxt();
    chk("t1_pf_req", {31'd0, bus.m_req}, 32'd1);
    chk("t1_pf_addr", bus.m_addr, 32'h00001001);

    // 2: step into the prefetched word
    nxt();
    i_addr = 32'h00001001;
    #1;
    chk("t2_stall", {31'd0, stall}, 32'd0);
    chk("t2_data", i_data, 32'hDEAD0002);
    lat = 3;
    nxt();
    chk("t2_pf_req", {31'd0, bus.m_req}, 32'd1);
    chk("t2_pf_addr", bus.m_addr, 32'h00001002);
    chk("t2_stall_prom", {31'd0, stall}, 32'd0);

    // 3: jump while a slow prefetch is outstanding
    i_addr = 32'h00002000;
    #1;
    chk("t3_stall_a", {31'd0, stall}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("t3_hold_addr", bus.m_addr, 32'h00001002);
      chk("t3_hold_req", {31'd0, bus.m_req}, 32'd1);
      chk("t3_hold_stall", {31'd0, stall}, 32'd1);
    end
    nxt();
    chk("t3_idle_req", {31'd0, bus.m_req}, 32'd0);
    chk("t3_idle_stall", {31'd0, stall}, 32'd1);
    lat = 0;
    nxt();
    chk("t3_dem_req", {31'd0, bus.m_req}, 32'd1);
    chk("t3_dem_addr", bus.m_addr, 32'h00002000);
    nxt();
    chk("t3_stall", {31'd0, stall}, 32'd0);
    chk("t3_data", i_data, 32'hDEAD1001);

    // 4: flush while demand 3000 is outstanding
    i_addr = 32'h00003000;
    lat = 2;
    #1;
    chk("t4_miss", {31'd0, stall}, 32'd1);
    nxt();
    chk("t4_req", {31'd0, bus.m_req}, 32'd1);
    chk("t4_addr", bus.m_addr, 32'h00003000);
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    #1;
    chk("t4_noack", {31'd0, bus.m_ack}, 32'd0);
    chk("t4_stall_a", {31'd0, stall}, 32'd1);
    nxt();
    chk("t4_ack", {31'd0, bus.m_ack}, 32'd1);
    chk("t4_stall_b", {31'd0, stall}, 32'd1);
    nxt();
    chk("t4_dropped", {31'd0, stall}, 32'd1);
    chk("t4_req_dn", {31'd0, bus.m_req}, 32'd0);
    lat = 0;
    nxt();
    chk("t4_rereq", {31'd0, bus.m_req}, 32'd1);
    chk("t4_readdr", bus.m_addr, 32'h00003000);
    nxt();
    chk("t4_stall", {31'd0, stall}, 32'd0);
    chk("t4_data", i_data, 32'hDEAD2001);

    // 5: prefetch wraps past the top of the address space
    i_addr = 32'hFFFFFFFF;
    nxt();
    chk("t5_dem_addr", bus.m_addr, 32'hFFFFFFFF);
    nxt();
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_data", i_data, 32'hDEACF000);
    nxt();
    chk("t5_pf_req", {31'd0, bus.m_req}, 32'd1);
    chk("t5_pf_addr", bus.m_addr, 32'h00000000);
    nxt();
    i_addr = 32'h00000000;
    #1;
    chk("t5_wrap_hit", {31'd0, stall}, 32'd0);
    chk("t5_wrap_data", i_data, 32'hDEACF001);
    lat = 5;

    // 6: reset during an outstanding request, then a stray ack
    nxt();
    chk("t6_req", {31'd0, bus.m_req}, 32'd1);
    chk("t6_addr", bus.m_addr, 32'h00000001);
    reset = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, bus.m_req}, 32'd0);
    chk("t6_rst_stall", {31'd0, stall}, 32'd1);
    chk("t6_rst_data", i_data, 32'd0);
    nxt();
    reset   = 1'b0;
    i_addr  = 32'h00000001;
    dat_frc = 32'h12345678;
    ack_frc = 1'b1;
    lat     = 0;
    nxt();
    ack_frc = 1'b0;
    #1;
    chk("t6_nofill", {31'd0, stall}, 32'd1);
    chk("t6_dem_req", {31'd0, bus.m_req}, 32'd1);
    chk("t6_dem_addr", bus.m_addr, 32'h00000001);
    nxt();
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_data", i_data, 32'hDEACF002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
